// File: rtl/cam_alloc_table_if.sv
// Request-side bundle of the CAM allocation table: alloc handshake, free and
// flush. The requester holds the master modport; the table holds the slave.

`ifndef ARCH_REGFILE_SIZE
`define ARCH_REGFILE_SIZE 32
`endif
`ifndef PHYS_REGFILE_SIZE
`define PHYS_REGFILE_SIZE 64
`endif

interface cam_alloc_table_if #(
    parameter int ARRAY_SIZE = `ARCH_REGFILE_SIZE,
    parameter int DATA_SIZE  = $clog2(`PHYS_REGFILE_SIZE)
);
    localparam int IDX_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

    logic                 alloc_req;
    logic [DATA_SIZE-1:0] alloc_data;
    logic                 alloc_gnt;
    logic [IDX_W-1:0]     alloc_idx;
    logic                 free_req;
    logic [IDX_W-1:0]     free_idx;
    logic                 flush;

    modport master (
        output alloc_req, alloc_data, free_req, free_idx, flush,
        input  alloc_gnt, alloc_idx
    );

    modport slave (
        input  alloc_req, alloc_data, free_req, free_idx, flush,
        output alloc_gnt, alloc_idx
    );
endinterface

// File: rtl/cam_alloc_table.sv
// Allocation table in front of a CAM: hands out the lowest free entry, stores
// data there, invalidates single entries on free and all entries on flush.
// Entry data is never cleared except by reset, so the CAM always sees stable
// contents; only the valid bits change on free/flush.

`ifndef ARCH_REGFILE_SIZE
`define ARCH_REGFILE_SIZE 32
`endif
`ifndef PHYS_REGFILE_SIZE
`define PHYS_REGFILE_SIZE 64
`endif

module cam_alloc_table #(
    parameter  int ARRAY_SIZE = `ARCH_REGFILE_SIZE,
    parameter  int DATA_SIZE  = $clog2(`PHYS_REGFILE_SIZE),
    localparam int IDX_W      = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1,
    localparam int CNT_W      = $clog2(ARRAY_SIZE + 1)
) (
    input  logic                                clock,
    input  logic                                reset_n,
    cam_alloc_table_if.slave                    bus,
    output logic [ARRAY_SIZE-1:0][DATA_SIZE-1:0] array,
    output logic [ARRAY_SIZE-1:0]               array_valid,
    output logic [CNT_W-1:0]                    count,
    output logic                                full,
    output logic                                empty
);

    logic [IDX_W-1:0]      free_slot;
    logic                  slot_found;
    logic                  grant;
    logic                  free_hit;
    logic [ARRAY_SIZE-1:0] valid_next;
    logic [CNT_W-1:0]      count_next;

    // Priority-encode the lowest invalid entry from the registered valid bits.
    always_comb begin
        free_slot  = '0;
        slot_found = 1'b0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            if (!slot_found && !array_valid[i]) begin
                free_slot  = IDX_W'(i);
                slot_found = 1'b1;
            end
        end
    end

    // Grant uses the registered full flag, so a same-cycle free cannot open a slot.
    assign grant    = reset_n & bus.alloc_req & ~full & ~bus.flush;
    assign free_hit = bus.free_req && (int'(bus.free_idx) < ARRAY_SIZE)
                      && array_valid[bus.free_idx];

    assign bus.alloc_gnt = grant;
    assign bus.alloc_idx = reset_n ? free_slot : '0;

    assign full  = (count == CNT_W'(ARRAY_SIZE));
    assign empty = (count == '0);

    // Next valid vector and count; the alloc slot is always invalid and the
    // freed slot always valid, so the two never collide and count stays in range.
    always_comb begin
        valid_next = array_valid;
        if (grant) begin
            valid_next[free_slot] = 1'b1;
        end
        if (free_hit) begin
            valid_next[bus.free_idx] = 1'b0;
        end
        count_next = count + CNT_W'(grant) - CNT_W'(free_hit);
    end

    // Table state: flush wins over alloc/free and leaves entry data untouched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            array       <= '0;
            array_valid <= '0;
            count       <= '0;
        end else if (bus.flush) begin
            array_valid <= '0;
            count       <= '0;
        end else begin
            if (grant) begin
                array[free_slot] <= bus.alloc_data;
            end
            array_valid <= valid_next;
            count       <= count_next;
        end
    end

endmodule

// File: tb/tb_cam_alloc_table.sv
// Directed and randomized checks of cam_alloc_table with a 4-entry, 6-bit table.

module tb_cam_alloc_table;

    localparam int AS = 4;
    localparam int DS = 6;

    logic clock = 1'b0;
    logic reset_n;

    logic [AS-1:0][DS-1:0] array;
    logic [AS-1:0]         array_valid;
    logic [2:0]            count;
    logic                  full;
    logic                  empty;

    int checks = 0;
    int passes = 0;

    logic [DS-1:0]         m_array [AS];
    logic [AS-1:0]         m_valid;
    logic [AS-1:0]         m_valid_pre;
    logic [AS-1:0][DS-1:0] m_packed;
    int                    m_count;
    logic                  r_areq, r_freq, r_flush, e_gnt, found;
    logic [DS-1:0]         r_data;
    logic [1:0]            r_fidx, e_idx;

    always #5 clock = ~clock;

    cam_alloc_table_if #(.ARRAY_SIZE(AS), .DATA_SIZE(DS)) bus ();

    cam_alloc_table #(.ARRAY_SIZE(AS), .DATA_SIZE(DS)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .array       (array),
        .array_valid (array_valid),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of requests, then settle before the next edge.
    task automatic apply_stimulus(input logic areq, input logic [DS-1:0] adata,
                                  input logic freq, input logic [1:0] fidx,
                                  input logic fl);
        bus.alloc_req  = areq;
        bus.alloc_data = adata;
        bus.free_req   = freq;
        bus.free_idx   = fidx;
        bus.flush      = fl;
        #2;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Run the directed scenarios, then randomized traffic against a model.
    initial begin
        reset_n        = 1'b0;
        bus.alloc_req  = 1'b1;
        bus.alloc_data = 6'h3F;
        bus.free_req   = 1'b0;
        bus.free_idx   = 2'd0;
        bus.flush      = 1'b0;
        #3;
        check_output("rst_array", array, 0);
        check_output("rst_valid", array_valid, 0);
        check_output("rst_count", count, 0);
        check_output("rst_empty", empty, 1);
        check_output("rst_full", full, 0);
        check_output("rst_gnt", bus.alloc_gnt, 0);
        check_output("rst_idx", bus.alloc_idx, 0);
        tick();
        check_output("rst_edge_valid", array_valid, 0);
        bus.alloc_req = 1'b0;
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, DS'(5 + i), 1'b0, 2'd0, 1'b0);
            check_output("fill_gnt", bus.alloc_gnt, 1);
            check_output("fill_idx", bus.alloc_idx, i);
            tick();
        end
        check_output("fill_array", array, {6'd8, 6'd7, 6'd6, 6'd5});
        check_output("fill_valid", array_valid, 4'b1111);
        check_output("fill_count", count, 4);
        check_output("fill_full", full, 1);
        check_output("fill_empty", empty, 0);

        apply_stimulus(1'b1, 6'd9, 1'b1, 2'd2, 1'b0);
        check_output("full_free_gnt", bus.alloc_gnt, 0);
        tick();
        apply_stimulus(1'b0, 6'd0, 1'b0, 2'd0, 1'b0);
        check_output("full_free_valid", array_valid, 4'b1011);
        check_output("full_free_count", count, 3);
        check_output("full_free_idx", bus.alloc_idx, 2);
        check_output("full_free_array", array, {6'd8, 6'd7, 6'd6, 6'd5});

        apply_stimulus(1'b1, 6'd10, 1'b1, 2'd1, 1'b0);
        check_output("both_gnt", bus.alloc_gnt, 1);
        check_output("both_idx", bus.alloc_idx, 2);
        tick();
        check_output("both_valid", array_valid, 4'b1101);
        check_output("both_count", count, 3);
        apply_stimulus(1'b0, 6'd0, 1'b1, 2'd3, 1'b0);
        tick();
        check_output("two_valid", array_valid, 4'b0101);
        check_output("two_count", count, 2);
        apply_stimulus(1'b0, 6'd0, 1'b1, 2'd1, 1'b0);
        tick();
        check_output("bad_free_valid", array_valid, 4'b0101);
        check_output("bad_free_count", count, 2);
        apply_stimulus(1'b1, 6'd3, 1'b0, 2'd0, 1'b0);
        check_output("hole_idx", bus.alloc_idx, 1);
        check_output("hole_gnt", bus.alloc_gnt, 1);
        tick();
        check_output("hole_valid", array_valid, 4'b0111);
        check_output("hole_count", count, 3);
        check_output("hole_array", array, {6'd8, 6'd10, 6'd3, 6'd5});

        apply_stimulus(1'b1, 6'd20, 1'b0, 2'd0, 1'b1);
        check_output("flush_gnt", bus.alloc_gnt, 0);
        tick();
        apply_stimulus(1'b0, 6'd0, 1'b0, 2'd0, 1'b0);
        check_output("flush_valid", array_valid, 0);
        check_output("flush_count", count, 0);
        check_output("flush_empty", empty, 1);
        check_output("flush_array", array, {6'd8, 6'd10, 6'd3, 6'd5});
        check_output("flush_idx", bus.alloc_idx, 0);

        apply_stimulus(1'b1, 6'd1, 1'b0, 2'd0, 1'b0);
        tick();
        apply_stimulus(1'b1, 6'd2, 1'b0, 2'd0, 1'b0);
        tick();
        apply_stimulus(1'b1, 6'd4, 1'b1, 2'd0, 1'b0);
        check_output("reuse_idx", bus.alloc_idx, 2);
        tick();
        apply_stimulus(1'b0, 6'd0, 1'b0, 2'd0, 1'b0);
        check_output("reuse_valid", array_valid, 4'b0110);
        check_output("reuse_count", count, 2);
        check_output("reuse_array", array, {6'd8, 6'd4, 6'd2, 6'd1});
        check_output("reuse_next_idx", bus.alloc_idx, 0);

        apply_stimulus(1'b1, 6'd7, 1'b0, 2'd0, 1'b0);
        reset_n = 1'b0;
        #1;
        check_output("async_array", array, 0);
        check_output("async_valid", array_valid, 0);
        check_output("async_count", count, 0);
        check_output("async_empty", empty, 1);
        check_output("async_gnt", bus.alloc_gnt, 0);
        check_output("async_idx", bus.alloc_idx, 0);
        tick();
        check_output("async_edge_valid", array_valid, 0);
        check_output("async_edge_array", array, 0);
        bus.alloc_req = 1'b0;
        reset_n = 1'b1;
        apply_stimulus(1'b1, 6'd33, 1'b0, 2'd0, 1'b0);
        check_output("post_rst_gnt", bus.alloc_gnt, 1);
        tick();
        check_output("post_rst_valid", array_valid, 4'b0001);
        check_output("post_rst_array", array, {6'd0, 6'd0, 6'd0, 6'd33});

        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        m_valid = '0;
        for (int j = 0; j < AS; j++) m_array[j] = '0;
        for (int c = 0; c < 10000; c++) begin
            r_areq  = 1'($urandom_range(0, 1));
            r_data  = DS'($urandom_range(0, 63));
            r_freq  = 1'($urandom_range(0, 1));
            r_fidx  = 2'($urandom_range(0, 3));
            r_flush = ($urandom_range(0, 15) == 0);
            m_count = $countones(m_valid);
            e_idx = 2'd0;
            found = 1'b0;
            for (int j = 0; j < AS; j++) begin
                if (!found && !m_valid[j]) begin
                    e_idx = 2'(j);
                    found = 1'b1;
                end
            end
            e_gnt = r_areq && (m_count != AS) && !r_flush;
            apply_stimulus(r_areq, r_data, r_freq, r_fidx, r_flush);
            check_output("rnd_gnt", bus.alloc_gnt, e_gnt);
            check_output("rnd_idx", bus.alloc_idx, e_idx);
            tick();
            m_valid_pre = m_valid;
            if (r_flush) begin
                m_valid = '0;
            end else begin
                if (e_gnt) begin
                    m_array[e_idx] = r_data;
                    m_valid[e_idx] = 1'b1;
                end
                if (r_freq && m_valid_pre[r_fidx]) m_valid[r_fidx] = 1'b0;
            end
            m_count = $countones(m_valid);
            for (int j = 0; j < AS; j++) m_packed[j] = m_array[j];
            check_output("rnd_array", array, m_packed);
            check_output("rnd_valid", array_valid, m_valid);
            check_output("rnd_count", count, m_count);
            check_output("rnd_full", full, m_count == AS);
            check_output("rnd_empty", empty, m_count == 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
